nmx1_wb_scheduler: RTL and testbench

NMX1_WB_SCHEDULER -- requirements
Module: nmx1_wb_scheduler

---
 rtl/nmx1_wb_scheduler.sv | 167 ++++++++++++++++
 tb/tb_nmx1_wb_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmx1_wb_scheduler.sv
// nmx1_wb_scheduler: two-requester round-robin front end for a single
// Wishbone master port to the Neuromorphic_X1 macro. Each accepted operation
// is run as one classic cycle with an ack timeout. A one-cycle response
// strobe follows, and a saturating counter records the timeouts.
module nmx1_wb_scheduler #(
  parameter int TIMEOUT = 255,
  parameter int ERRW    = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // requester 0 (management SoC)
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic            r0_we,
  input  logic [3:0]      r0_sel,
  input  logic [31:0]     r0_adr,
  input  logic [31:0]     r0_dat,
  // requester 1 (LA test engine)
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic            r1_we,
  input  logic [3:0]      r1_sel,
  input  logic [31:0]     r1_adr,
  input  logic [31:0]     r1_dat,
  // Wishbone master port
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  output logic [3:0]      m_sel_o,
  output logic [31:0]     m_adr_o,
  output logic [31:0]     m_dat_o,
  input  logic [31:0]     m_dat_i,
  input  logic            m_ack_i,
  // response / status
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic            rsp_err,
  output logic [31:0]     rsp_dat,
  output logic            busy,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Last BUS cycle index (counter is cleared on entry, so cycle n holds n-1).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_gid;
  logic [7:0]       r_tmo_cnt;
  logic             r_cyc;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_dat;
  logic [ERRW-1:0]  r_err_cnt;

  logic             w_grant;
  logic             w_grant_id;
  logic             w_g_we;
  logic [3:0]       w_g_sel;
  logic [31:0]      w_g_adr;
  logic [31:0]      w_g_dat;
  logic             w_tmo_hit;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_grant    = (r_state == S_IDLE) && !wb_rst_i && (r0_valid || r1_valid);
    w_grant_id = (r0_valid && r1_valid) ? ~r_last_grant : r1_valid;
    w_g_we     = w_grant_id ? r1_we  : r0_we;
    w_g_sel    = w_grant_id ? r1_sel : r0_sel;
    w_g_adr    = w_grant_id ? r1_adr : r0_adr;
    w_g_dat    = w_grant_id ? r1_dat : r0_dat;
    w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
  end

  assign r0_ready = w_grant && !w_grant_id;
  assign r1_ready = w_grant &&  w_grant_id;

  // Main FSM: grant in IDLE, hold the bus cycle in BUS, pulse the response in RESP.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gid        <= 1'b0;
      r_tmo_cnt    <= 8'd0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_sel        <= 4'd0;
      r_adr        <= 32'd0;
      r_dat        <= 32'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_dat    <= 32'd0;
      r_err_cnt    <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_last_grant <= w_grant_id;
            r_gid        <= w_grant_id;
            r_tmo_cnt    <= 8'd0;
            r_cyc        <= 1'b1;
            r_we         <= w_g_we;
            r_sel        <= w_g_sel;
            r_adr        <= w_g_adr;
            r_dat        <= w_g_dat;
            r_state      <= S_BUS;
          end
        end
        S_BUS: begin
          // An ack on the final allowed cycle still counts as success.
          if (m_ack_i || w_tmo_hit) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gid;
            r_state     <= S_RESP;
            if (m_ack_i) begin
              r_rsp_err <= 1'b0;
              r_rsp_dat <= r_we ? 32'd0 : m_dat_i;
            end else begin
              r_rsp_err <= 1'b1;
              r_rsp_dat <= 32'd0;
              if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
              end
            end
          end
          if (!m_ack_i) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_cyc_o   = r_cyc;
  assign m_stb_o   = r_cyc;
  assign m_we_o    = r_we;
  assign m_sel_o   = r_sel;
  assign m_adr_o   = r_adr;
  assign m_dat_o   = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign rsp_dat   = r_rsp_dat;
  assign busy      = (r_state != S_IDLE);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_nmx1_wb_scheduler.sv
// Testbench for nmx1_wb_scheduler: directed scenarios followed by randomized
// operations. Expected responses go into a scoreboard queue and are checked
// by an independent monitor.
module tb_nmx1_wb_scheduler;

  localparam int TO = 4;
  localparam int EW = 3;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  typedef struct packed {
    logic          id;
    logic          err;
    logic [31:0]   dat;
    logic [EW-1:0] ecnt;
  } exp_t;

  logic          clk;
  logic          wb_rst_i;
  logic          r0_valid, r0_ready, r0_we;
  logic [3:0]    r0_sel;
  logic [31:0]   r0_adr, r0_dat;
  logic          r1_valid, r1_ready, r1_we;
  logic [3:0]    r1_sel;
  logic [31:0]   r1_adr, r1_dat;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]    m_sel_o;
  logic [31:0]   m_adr_o, m_dat_o, m_dat_i;
  logic          m_ack_i;
  logic          rsp_valid, rsp_id, rsp_err;
  logic [31:0]   rsp_dat;
  logic          busy;
  logic [EW-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  exp_t          sb[$];
  bit            mdl_last;
  logic [EW-1:0] mdl_ecnt;
  logic          hold_id, hold_err;
  logic [31:0]   hold_dat;
  logic [EW-1:0] hold_ecnt;
  bit            mon_en = 0;

  nmx1_wb_scheduler #(.TIMEOUT(TO), .ERRW(EW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_sel(r0_sel),
    .r0_adr(r0_adr), .r0_dat(r0_dat),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_sel(r1_sel),
    .r1_adr(r1_adr), .r1_dat(r1_dat),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_dat(rsp_dat),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.we  = 1'($urandom_range(0, 1));
    r.sel = 4'($urandom);
    r.adr = $urandom;
    r.dat = $urandom;
    return r;
  endfunction

  task automatic drive_fields(input req_t q0, input req_t q1);
    r0_we = q0.we; r0_sel = q0.sel; r0_adr = q0.adr; r0_dat = q0.dat;
    r1_we = q1.we; r1_sel = q1.sel; r1_adr = q1.adr; r1_dat = q1.dat;
  endtask

  // Invariant checker: ready exclusivity, no ready while busy, bus quiet outside a cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk1("ready_exclusive", r0_ready & r1_ready, 1'b0);
      chk1("ready_while_busy", busy & (r0_ready | r1_ready), 1'b0);
      chk1("stb_follows_cyc", m_stb_o, m_cyc_o);
      if (!m_cyc_o) begin
        chk1("bus_zero_when_idle", m_we_o || (|m_sel_o) || (|m_adr_o) || (|m_dat_o), 1'b0);
      end
    end
  end

  // Monitor: pops the scoreboard on each response and checks held values otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d expected no response at %0t",
                   rsp_id, $time);
        end else begin
          e = sb.pop_front();
          chk1("rsp_id", rsp_id, e.id);
          chk1("rsp_err", rsp_err, e.err);
          chk32("rsp_dat", rsp_dat, e.dat);
          chk32("err_cnt", 32'(err_cnt), 32'(e.ecnt));
          hold_id   = e.id;
          hold_err  = e.err;
          hold_dat  = e.dat;
          hold_ecnt = e.ecnt;
          $display("[TB] rsp id=%0d err=%0d dat=0x%08h err_cnt=%0d",
                   rsp_id, rsp_err, rsp_dat, err_cnt);
        end
      end else begin
        chk1("hold_id", rsp_id, hold_id);
        chk1("hold_err", rsp_err, hold_err);
        chk32("hold_dat", rsp_dat, hold_dat);
        chk32("hold_err_cnt", 32'(err_cnt), 32'(hold_ecnt));
      end
    end
  end

  task automatic reset_model();
    mdl_last  = 1'b1;
    mdl_ecnt  = '0;
    hold_id   = 1'b0;
    hold_err  = 1'b0;
    hold_dat  = 32'd0;
    hold_ecnt = '0;
    sb.delete();
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    wb_rst_i = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; m_ack_i = 1'b0;
    @(posedge clk); #1;
    reset_model();
    r0_valid = 1'b1; r1_valid = 1'b1;
    @(negedge clk);
    chk1("rst_ready0", r0_ready, 1'b0);
    chk1("rst_ready1", r1_ready, 1'b0);
    chk1("rst_cyc", m_cyc_o, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  // Present requests in an IDLE cycle and check which requester is accepted.
  task automatic issue(input bit v0, input bit v1, input req_t q0, input req_t q1,
                       output bit g, output req_t gq);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    r0_valid = v0; r1_valid = v1; m_ack_i = 1'b0; m_dat_i = $urandom;
    drive_fields(q0, q1);
    g = (v0 && v1) ? !mdl_last : v1;
    mdl_last = g;
    gq = g ? q1 : q0;
    @(negedge clk);
    chk1("busy_at_grant", busy, 1'b0);
    chk1("cyc_at_grant", m_cyc_o, 1'b0);
    chk1("r0_ready", r0_ready, !g);
    chk1("r1_ready", r1_ready, g);
  endtask

  // Run the bus phase: ackd = BUS cycle carrying the ack (1..TO), 0 = never.
  task automatic complete(input bit g, input req_t gq, input int ackd, input logic [31:0] rdata);
    exp_t e;
    bit   done;
    e.id  = g;
    e.err = (ackd == 0);
    e.dat = (ackd == 0 || gq.we) ? 32'd0 : rdata;
    if (ackd == 0 && mdl_ecnt != {EW{1'b1}}) mdl_ecnt++;
    e.ecnt = mdl_ecnt;
    sb.push_back(e);
    done = 1'b0;
    for (int i = 1; i <= TO && !done; i++) begin
      @(posedge clk); #1;
      drive_fields(rnd_req(), rnd_req());
      m_ack_i = (i == ackd);
      m_dat_i = (i == ackd) ? rdata : $urandom;
      @(negedge clk);
      chk1("bus_cyc", m_cyc_o, 1'b1);
      chk1("bus_stb", m_stb_o, 1'b1);
      chk1("bus_we", m_we_o, gq.we);
      chk32("bus_sel", 32'(m_sel_o), 32'(gq.sel));
      chk32("bus_adr", m_adr_o, gq.adr);
      chk32("bus_dat", m_dat_o, gq.dat);
      if (i == ackd) done = 1'b1;
    end
    @(posedge clk); #1;
    m_ack_i = 1'($urandom_range(0, 1));
    m_dat_i = $urandom;
    @(negedge clk);
    chk1("resp_valid", rsp_valid, 1'b1);
    chk1("resp_cyc_dropped", m_cyc_o, 1'b0);
    chk1("resp_busy", busy, 1'b1);
  endtask

  task automatic idle(input int n, input bit spur);
    repeat (n) begin
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      m_ack_i = spur; m_dat_i = $urandom;
      @(negedge clk);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_cyc", m_cyc_o, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   g;
    req_t gq, q0, q1, qz;
    int   ackd;
    qz = '0;
    wb_rst_i = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; m_ack_i = 1'b0; m_dat_i = 32'd0;
    drive_fields(qz, qz);
    reset_model();
    @(posedge clk); #1;
    mon_en = 1;
    do_rst();

    // r0 write acked on the 2nd BUS cycle
    q0 = '{we: 1'b1, sel: 4'hF, adr: 32'h3000_0004, dat: 32'hA5A5_0001};
    issue(1'b1, 1'b0, q0, qz, g, gq);
    complete(g, gq, 2, 32'h1234_5678);
    idle(1, 1'b0);

    // r1 read returning DEADBEEF
    q1 = '{we: 1'b0, sel: 4'hF, adr: 32'h3000_0010, dat: 32'h0};
    issue(1'b0, 1'b1, qz, q1, g, gq);
    complete(g, gq, 1, 32'hDEAD_BEEF);

    // timeout, then a spurious ack while idle
    issue(1'b1, 1'b0, rnd_req(), qz, g, gq);
    complete(g, gq, 0, 32'hCAFE_0000);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // ack on the last allowed cycle wins
    q1.we = 1'b0;
    issue(1'b0, 1'b1, qz, q1, g, gq);
    complete(g, gq, TO, 32'h0BAD_F00D);

    // round robin with both requesters continuously valid after reset
    do_rst();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, rnd_req(), rnd_req(), g, gq);
      chk1("rr_order", g, (i % 2) == 1);
      complete(g, gq, $urandom_range(1, TO), $urandom);
    end
    idle(1, 1'b0);

    // reset during BUS aborts the operation; r1 is granted right after release
    issue(1'b1, 1'b0, rnd_req(), qz, g, gq);
    @(posedge clk); #1;
    m_ack_i = 1'b0;
    @(negedge clk);
    chk1("abort_bus1_cyc", m_cyc_o, 1'b1);
    @(posedge clk); #1;
    wb_rst_i = 1'b1; r0_valid = 1'b0; r1_valid = 1'b1;
    @(negedge clk);
    chk1("abort_rst_ready1", r1_ready, 1'b0);
    #1;
    reset_model();
    q1 = rnd_req();
    issue(1'b0, 1'b1, qz, q1, g, gq);
    complete(g, gq, 1, $urandom);

    // drive err_cnt into saturation
    for (int i = 0; i < (1 << EW) + 1; i++) begin
      issue(1'b1, 1'b0, rnd_req(), qz, g, gq);
      complete(g, gq, 0, $urandom);
    end

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      int v;
      v = $urandom_range(1, 3);
      ackd = $urandom_range(0, TO);
      issue(v[0], v[1], rnd_req(), rnd_req(), g, gq);
      complete(g, gq, ackd, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end

    idle(2, 1'b0);
    chk32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
